// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and stage-bundle widths for elastic pipeline registers
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } state_e;

  // Bundle layouts used to size DATA_W when a stage register is instantiated.
  localparam int XLEN         = 32;
  localparam int REG_IDX_W    = 5;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_CTRL_W = 6;
  localparam int IDEX_W       = IDEX_CTRL_W + 4 * XLEN + REG_IDX_W;
  localparam int EXMEM_W      = EXMEM_CTRL_W + 2 * XLEN + REG_IDX_W;

  function automatic logic [1:0] occupancy_of(input state_e s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready payload channel between pipeline stages
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 128
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with one-entry skid, flush bubble and perf counters
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  logic in_fire;
  logic out_fire;
  logic out_valid;

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_fire   = in_if.valid & in_ready_q;
    out_fire  = out_valid & out_if.ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Squash: drop everything held plus anything offered this cycle.
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_if.data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_if.data;
          end else if (in_fire) begin
            state_d = S_TWO;
            skid_d  = in_if.data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
            main_d  = '0;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // main_q is cleared on every path to EMPTY, so an idle stage presents an all-zero NOP bundle.
  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;
  assign occupancy    = occupancy_of(state_q);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_if.ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for the elastic pipeline stage
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_W(128)) in_if ();
  pipe_stage_elastic_if #(.DATA_W(128)) out_if ();
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  pipe_stage_elastic #(.DATA_W(128), .CNT_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_if      (in_if),
    .out_if     (out_if),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  // Idle narrow-counter instance for the saturation check.
  pipe_stage_elastic_if #(.DATA_W(128)) s_in_if ();
  pipe_stage_elastic_if #(.DATA_W(128)) s_out_if ();
  logic [1:0] s_occupancy;
  logic [3:0] s_stall_cnt;
  logic [3:0] s_bubble_cnt;

  assign s_in_if.valid  = 1'b0;
  assign s_in_if.data   = '0;
  assign s_out_if.ready = 1'b0;

  pipe_stage_elastic #(.DATA_W(128), .CNT_W(4)) u_dut_sat (
    .clk        (clk),
    .reset      (reset),
    .flush      (1'b0),
    .in_if      (s_in_if),
    .out_if     (s_out_if),
    .occupancy  (s_occupancy),
    .stall_cnt  (s_stall_cnt),
    .bubble_cnt (s_bubble_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] q[$];
  logic [15:0]  exp_stall;
  logic [15:0]  exp_bubble;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected contents of the stage, updated with the fires seen before each edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_stall  = '0;
      exp_bubble = '0;
    end else begin
      chk("occupancy", {126'd0, occupancy}, q.size());
      chk("in_ready", {127'd0, in_if.ready}, {127'd0, q.size() < 2});
      chk("out_valid", {127'd0, out_if.valid}, {127'd0, q.size() != 0});
      if (!out_if.valid) chk("bubble_zero", out_if.data, '0);
      else if (q.size() != 0) chk("order", out_if.data, q[0]);
      chk("stall_model", {112'd0, stall_cnt}, {112'd0, exp_stall});
      chk("bubble_model", {112'd0, bubble_cnt}, {112'd0, exp_bubble});
      if (q.size() != 0 && !out_if.ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (q.size() == 0 && exp_bubble != 16'hFFFF) exp_bubble = exp_bubble + 16'd1;
      if (out_if.valid && out_if.ready && q.size() != 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_if.valid && in_if.ready) q.push_back(in_if.data);
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = 128'hDEAD;
    out_if.ready = 1'b0;
    tick(2);
    chk("rst_out_valid", {127'd0, out_if.valid}, '0);
    chk("rst_out_data", out_if.data, '0);
    chk("rst_in_ready", {127'd0, in_if.ready}, 128'd1);
    chk("rst_occupancy", {126'd0, occupancy}, '0);
    chk("rst_stall", {112'd0, stall_cnt}, '0);
    chk("rst_bubble", {112'd0, bubble_cnt}, '0);

    reset       = 1'b0;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    tick(5);
    chk("sat_bubble_5", {124'd0, s_bubble_cnt}, 128'd5);
    chk("bubble_5", {112'd0, bubble_cnt}, 128'd5);
    tick(15);
    chk("sat_bubble_max", {124'd0, s_bubble_cnt}, 128'd15);
    tick(5);
    chk("sat_bubble_hold", {124'd0, s_bubble_cnt}, 128'd15);
    chk("bubble_25", {112'd0, bubble_cnt}, 128'd25);

    // Streaming at full rate.
    out_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = 128'(i);
      tick(1);
      chk("stream_valid", {127'd0, out_if.valid}, 128'd1);
      chk("stream_data", out_if.data, 128'(i));
      chk("stream_in_ready", {127'd0, in_if.ready}, 128'd1);
    end
    in_if.valid = 1'b0;
    tick(3);
    chk("stream_stall", {112'd0, stall_cnt}, '0);
    chk("stream_drain", {126'd0, occupancy}, '0);

    // Backpressure fills the skid entry.
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = 128'hA1;
    tick(1);
    in_if.data = 128'hA2;
    tick(1);
    chk("bp_occupancy", {126'd0, occupancy}, 128'd2);
    chk("bp_in_ready", {127'd0, in_if.ready}, '0);
    in_if.data = 128'hA3;
    tick(3);
    chk("bp_stall", {112'd0, stall_cnt}, 128'd4);
    chk("bp_head", out_if.data, 128'hA1);
    out_if.ready = 1'b1;
    tick(1);
    chk("bp_second", out_if.data, 128'hA2);
    chk("bp_reopen", {127'd0, in_if.ready}, 128'd1);
    tick(1);
    in_if.valid = 1'b0;
    chk("bp_third", out_if.data, 128'hA3);
    tick(2);
    chk("bp_stall_final", {112'd0, stall_cnt}, 128'd4);

    // Flush while full with a new offer pending.
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = 128'hB1;
    tick(1);
    in_if.data = 128'hB2;
    tick(1);
    in_if.data = 128'hB3;
    flush      = 1'b1;
    tick(1);
    flush       = 1'b0;
    in_if.valid = 1'b0;
    chk("flush_valid", {127'd0, out_if.valid}, '0);
    chk("flush_data", out_if.data, '0);
    chk("flush_occupancy", {126'd0, occupancy}, '0);
    chk("flush_in_ready", {127'd0, in_if.ready}, 128'd1);
    out_if.ready = 1'b1;
    tick(2);
    chk("flush_no_b3", {127'd0, out_if.valid}, '0);

    // Random valid/ready traffic with occasional flushes.
    for (int i = 0; i < 1000; i++) begin
      in_if.valid  = 1'($urandom_range(0, 1));
      in_if.data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_if.ready = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    tick(4);
    chk("rand_drained", 128'(q.size()), '0);
    chk("rand_occupancy", {126'd0, occupancy}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed-field, condition-coded inter-stage registers with a single generic block.
- Carries an opaque payload of DATA_W bits (packed control plus data bundle) between two stages using a valid/ready handshake.
- A one-entry skid buffer gives full throughput with a registered in_ready.
- Adds a synchronous flush that inserts an all-zero bubble, and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 128, payload width in bits (packed stage bundle).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all held entries this cycle (branch/jump squash).
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload to downstream; all-zero when out_valid=0.
- occupancy  output  2  entries held (0..2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  output  CNT_W  cycles with out_valid=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Priority: reset > flush > normal operation.
- Reset values: state EMPTY, main and skid registers 0, in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0, bubble_cnt=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may drop without a transfer. Payload is only sampled on in_fire.
- State machine (out_data = main register always):
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay in EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire only -> TWO, skid<=in_data.
    - out_fire only -> EMPTY, main<=0.
    - neither -> hold.
  - TWO:
    - out_fire -> ONE, main<=skid, skid<=0.
    - otherwise hold. in_fire is impossible because in_ready=0.
- Derived outputs:
  - in_ready = (state != TWO), driven from a register updated with the next state.
  - out_valid = (state != EMPTY).
  - occupancy: EMPTY=0, ONE=1, TWO=2.
- Latency and throughput: 1 cycle from in_fire in EMPTY to out_valid. Sustained 1 transfer/cycle when out_ready stays high. Strict FIFO order, no loss, no duplication.
- Bubble encoding: main is zero whenever the stage is empty, so downstream decode of an all-zero bundle is a NOP.
- Flush:
  - Next state EMPTY; main and skid <= 0; in_ready=1 next cycle.
  - in_data offered in the flush cycle is dropped, even if in_fire is high.
  - An out_fire in the flush cycle still counts as delivered downstream.
- Counters:
  - Evaluated each non-reset cycle (flush cycles included) from the current out_valid/out_ready.
  - Saturate at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Simultaneous events: flush together with in_valid/out_ready follows the flush rule above. reset together with flush behaves as reset.

Decomposition:
- Shared package pipe_pkg:
  - State localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Stage-bundle width constants (control-field widths, total ID/EX and EX/MEM bundle widths) used to set DATA_W at instantiation.
- One sub-module, sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Reset: assert reset for 2 cycles while in_valid=1 -> out_valid=0, out_data=0, in_ready=1, counters=0.
- Streaming: push 0x01..0x08 with out_ready=1 continuously -> out_data 0x01..0x08 on consecutive cycles, first at 1 cycle latency; stall_cnt stays 0.
- Backpressure: out_ready=0, push 0xA1, 0xA2 -> occupancy=2, in_ready=0; a third value 0xA3 is held by upstream. Raise out_ready -> outputs A1, A2, A3 in order; stall_cnt counts the blocked cycles exactly.
- Flush at full: occupancy=2 with in_valid=1 (0xB3) and flush=1 -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xB3 never appears.
- Counter saturation: CNT_W=4, idle 20 cycles after reset -> bubble_cnt reaches 15 and holds.
- Simultaneous in/out fire in ONE with random valid/ready for 1000 cycles -> a scoreboard shows order preserved, no loss, and out_data=0 whenever out_valid=0.
